// File: rtl/ns_link_arbiter_pkg.sv
// Shared types and constants for the ns_link_arbiter slice.
// Holds the arbiter state encoding and the default packet width.
package ns_link_arbiter_pkg;

  // Default packet width (address + data + redundancy) in bits
  localparam int NS_PACKET_SIZE = 16;

  // Arbiter state encoding, two bits wide
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ns_link_arbiter_rr_pick.sv
// ns_rr_pick: combinational round-robin search.
// Finds the first set request bit starting one position after 'last',
// wrapping modulo NSRC, so the last winner always has lowest priority.
module ns_rr_pick #(
  parameter int NSRC = 4,
  parameter int IDXW = 2
) (
  input  logic [NSRC-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic            found,
  output logic [IDXW-1:0] next
);

  logic [2*NSRC-1:0] rotated;

  // Rotate the doubled request vector so bit 0 is the source after 'last',
  // then take the lowest set bit and map it back to a source index
  always_comb begin
    found   = 1'b0;
    next    = last;
    rotated = {req, req} >> (int'(last) + 1);
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        found = 1'b1;
        next  = IDXW'((int'(last) + 1 + i) % NSRC);
      end
    end
  end

endmodule

// File: rtl/ns_link_arbiter.sv
// ns_link_arbiter: round-robin arbiter sharing one 4-phase packet link
// between NSRC 4-phase source links. The granted packet is latched, sent on
// the destination link, and both handshakes close before re-arbitration.
// Optional feature macro: NS_LINK_ARB_STATS_EN adds pkt_cnt and err_flag.
module ns_link_arbiter
  import ns_link_arbiter_pkg::*;
#(
  parameter int PSZ  = NS_PACKET_SIZE,
  parameter int NSRC = 4,
  parameter int IDXW = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NSRC-1:0]     src_req,
  input  logic [NSRC*PSZ-1:0] src_data,
  output logic [NSRC-1:0]     src_ack,
  output logic                dst_req,
  output logic [PSZ-1:0]      dst_data,
  input  logic                dst_ack,
  output logic [IDXW-1:0]     grant_idx,
  output logic                busy
`ifdef NS_LINK_ARB_STATS_EN
  ,
  output logic [15:0]         pkt_cnt,
  output logic                err_flag
`endif
);

  arb_state_t      state;
  logic            pick_found;
  logic [IDXW-1:0] pick_idx;
  logic [PSZ-1:0]  pick_data;

  ns_rr_pick #(
    .NSRC (NSRC),
    .IDXW (IDXW)
  ) u_pick (
    .req   (src_req),
    .last  (grant_idx),
    .found (pick_found),
    .next  (pick_idx)
  );

  // Select the packet belonging to the source the search would grant
  always_comb begin
    pick_data = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (pick_idx == IDXW'(k)) begin
        pick_data = src_data[k*PSZ +: PSZ];
      end
    end
  end

  assign busy = (state != ST_IDLE);

  // Handshake state machine: grant in IDLE, forward in REQ, close both sides in ACK
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      src_ack   <= '0;
      dst_req   <= 1'b0;
      dst_data  <= '0;
      grant_idx <= IDXW'(NSRC - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            dst_data  <= pick_data;
            grant_idx <= pick_idx;
            dst_req   <= 1'b1;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (dst_ack) begin
            dst_req <= 1'b0;
            src_ack <= NSRC'(1) << grant_idx;
            state   <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (!src_req[grant_idx] && !dst_ack) begin
            src_ack <= '0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          src_ack <= '0;
          dst_req <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef NS_LINK_ARB_STATS_EN
  // Count completed transfers and flag an acknowledge seen while idle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pkt_cnt  <= '0;
      err_flag <= 1'b0;
    end else begin
      if (state == ST_ACK && !src_req[grant_idx] && !dst_ack) begin
        pkt_cnt <= pkt_cnt + 16'd1;
      end
      if (state == ST_IDLE && dst_ack) begin
        err_flag <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ns_link_arbiter.sv
// Directed testbench for ns_link_arbiter (PSZ=16, NSRC=4, IDXW=2).
// Build with NS_LINK_ARB_STATS_EN defined to also exercise pkt_cnt/err_flag.
module tb_ns_link_arbiter;

  localparam int PSZ  = 16;
  localparam int NSRC = 4;
  localparam int IDXW = 2;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [NSRC-1:0]     src_req;
  logic [NSRC*PSZ-1:0] src_data;
  logic [NSRC-1:0]     src_ack;
  logic                dst_req;
  logic [PSZ-1:0]      dst_data;
  logic                dst_ack;
  logic [IDXW-1:0]     grant_idx;
  logic                busy;
`ifdef NS_LINK_ARB_STATS_EN
  logic [15:0]         pkt_cnt;
  logic                err_flag;
`endif

  int check_count = 0;
  int pass_count  = 0;
  int fail_count  = 0;

  ns_link_arbiter #(
    .PSZ  (PSZ),
    .NSRC (NSRC),
    .IDXW (IDXW)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .src_req   (src_req),
    .src_data  (src_data),
    .src_ack   (src_ack),
    .dst_req   (dst_req),
    .dst_data  (dst_data),
    .dst_ack   (dst_ack),
    .grant_idx (grant_idx),
    .busy      (busy)
`ifdef NS_LINK_ARB_STATS_EN
    ,
    .pkt_cnt   (pkt_cnt),
    .err_flag  (err_flag)
`endif
  );

  // Free-running clock, 10 time units per period
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NSRC-1:0] req, input logic ack);
    src_req = req;
    dst_ack = ack;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected) begin
      pass_count++;
    end else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One complete 4-phase transfer with a consumer that acks immediately
  task automatic runTransfer(input int exp_idx, input logic [PSZ-1:0] exp_data);
    for (int n = 0; n < 10 && dst_req !== 1'b1; n++) tick();
    checkOutput("xfer_dst_req", 32'(dst_req), 32'd1);
    checkOutput("xfer_grant", 32'(grant_idx), 32'(exp_idx));
    checkOutput("xfer_data", 32'(dst_data), 32'(exp_data));
    checkOutput("xfer_busy", 32'(busy), 32'd1);
    dst_ack = 1'b1;
    tick();
    checkOutput("xfer_src_ack", 32'(src_ack), 32'(4'b0001 << exp_idx));
    checkOutput("xfer_dst_req_low", 32'(dst_req), 32'd0);
    src_req = src_req & ~(4'b0001 << exp_idx);
    dst_ack = 1'b0;
    tick();
    checkOutput("xfer_src_ack_low", 32'(src_ack), 32'd0);
    checkOutput("xfer_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    src_data = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    i_rst    = 1'b1;
    applyStimulus(4'b1111, 1'b0);

    // Reset with every source requesting
    tick();
    checkOutput("rst_src_ack", 32'(src_ack), 32'd0);
    checkOutput("rst_dst_req", 32'(dst_req), 32'd0);
    checkOutput("rst_dst_data", 32'(dst_data), 32'd0);
    checkOutput("rst_grant", 32'(grant_idx), 32'd3);
    checkOutput("rst_busy", 32'(busy), 32'd0);

    // First grant goes to source 0, dst_req one cycle after release
    i_rst = 1'b0;
    tick();
    checkOutput("lat_dst_req", 32'(dst_req), 32'd1);
    runTransfer(0, 16'hD000);

    // All sources held requesting: strict rotation 1,2,3 then back to 0
    src_req = 4'b1111;
    runTransfer(1, 16'hD001);
    src_req = 4'b1111;
    runTransfer(2, 16'hD002);
    src_req = 4'b1111;
    runTransfer(3, 16'hD003);
    src_req = 4'b1111;
    runTransfer(0, 16'hD000);

    // Single requester on source 2, five packets in order
    for (int i = 0; i < 5; i++) begin
      src_data[2*PSZ +: PSZ] = 16'h00A1 + 16'(i);
      src_req = 4'b0100;
      runTransfer(2, 16'h00A1 + 16'(i));
    end

    // ACK exit: source drops first, consumer releases three cycles later
    applyStimulus(4'b0001, 1'b0);
    tick();
    checkOutput("a_grant", 32'(grant_idx), 32'd0);
    dst_ack = 1'b1;
    tick();
    src_req = 4'b0000;
    tick();
    tick();
    tick();
    checkOutput("a_hold_ack", 32'(src_ack), 32'h1);
    checkOutput("a_hold_busy", 32'(busy), 32'd1);
    dst_ack = 1'b0;
    tick();
    checkOutput("a_exit_ack", 32'(src_ack), 32'd0);
    checkOutput("a_exit_busy", 32'(busy), 32'd0);

    // ACK exit: consumer releases first, source drops three cycles later
    applyStimulus(4'b0010, 1'b0);
    tick();
    checkOutput("b_grant", 32'(grant_idx), 32'd1);
    dst_ack = 1'b1;
    tick();
    dst_ack = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("b_hold_ack", 32'(src_ack), 32'h2);
    checkOutput("b_hold_busy", 32'(busy), 32'd1);
    src_req = 4'b0000;
    tick();
    checkOutput("b_exit_ack", 32'(src_ack), 32'd0);
    checkOutput("b_exit_busy", 32'(busy), 32'd0);

    // ACK exit: both sides release on the same cycle
    applyStimulus(4'b1000, 1'b0);
    tick();
    checkOutput("c_grant", 32'(grant_idx), 32'd3);
    dst_ack = 1'b1;
    tick();
    checkOutput("c_ack", 32'(src_ack), 32'h8);
    applyStimulus(4'b0000, 1'b0);
    tick();
    checkOutput("c_exit_ack", 32'(src_ack), 32'd0);
    checkOutput("c_exit_busy", 32'(busy), 32'd0);

    // Reset while in REQ drops everything at once
    src_data[2*PSZ +: PSZ] = 16'hD002;
    applyStimulus(4'b0001, 1'b0);
    tick();
    checkOutput("r_req_up", 32'(dst_req), 32'd1);
    checkOutput("r_data", 32'(dst_data), 32'hD000);
    i_rst = 1'b1;
    tick();
    checkOutput("r_dst_req", 32'(dst_req), 32'd0);
    checkOutput("r_src_ack", 32'(src_ack), 32'd0);
    checkOutput("r_grant", 32'(grant_idx), 32'd3);
    checkOutput("r_busy", 32'(busy), 32'd0);
    checkOutput("r_dst_data", 32'(dst_data), 32'd0);
    i_rst = 1'b0;
    applyStimulus(4'b0000, 1'b0);
    tick();

    // Spurious dst_ack while idle is ignored
    dst_ack = 1'b1;
    tick();
    checkOutput("sp_busy", 32'(busy), 32'd0);
    checkOutput("sp_dst_req", 32'(dst_req), 32'd0);
    checkOutput("sp_src_ack", 32'(src_ack), 32'd0);
    dst_ack = 1'b0;
    tick();
    checkOutput("sp_grant", 32'(grant_idx), 32'd3);

`ifdef NS_LINK_ARB_STATS_EN
    // Statistics: error flag sticks, three transfers counted, reset clears both
    checkOutput("st_err_set", 32'(err_flag), 32'd1);
    checkOutput("st_cnt0", 32'(pkt_cnt), 32'd0);
    src_req = 4'b0001;
    runTransfer(0, 16'hD000);
    src_req = 4'b0010;
    runTransfer(1, 16'hD001);
    src_req = 4'b0100;
    runTransfer(2, 16'hD002);
    checkOutput("st_cnt3", 32'(pkt_cnt), 32'd3);
    checkOutput("st_err_sticky", 32'(err_flag), 32'd1);
    i_rst = 1'b1;
    tick();
    checkOutput("st_cnt_rst", 32'(pkt_cnt), 32'd0);
    checkOutput("st_err_rst", 32'(err_flag), 32'd0);
    i_rst = 1'b0;
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
